// File: rtl/multu_pkg.sv
// Shared types and saturation helpers for the pipelined Q-format multiplier.
package multu_pkg;

  typedef enum logic {
    RND_TRUNC     = 1'b0,
    RND_HALF_AWAY = 1'b1
  } rnd_e;

  // Sideband carried alongside the magnitude payload through S1/S2.
  typedef struct packed {
    logic sign;
    rnd_e rnd;
  } stage_ctl_t;

  localparam int unsigned SAT_W = 128;

  function automatic logic [SAT_W-1:0] sat_max(input int unsigned n);
    return (SAT_W'(1) << (n - 1)) - SAT_W'(1);
  endfunction

  function automatic logic [SAT_W-1:0] sat_min(input int unsigned n);
    return SAT_W'(1) << (n - 1);
  endfunction

endpackage

// File: rtl/multu_sat_round.sv
// Combinational S3 stage: scale the magnitude product, round, saturate, restore sign.
module multu_sat_round
  import multu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 18
) (
  input  logic [2*N-1:0] prod,
  input  logic           sign,
  input  rnd_e           rnd,
  output logic [N-1:0]   res,
  output logic           ovf
);

  localparam int unsigned MW = 2 * N + 1;
  localparam logic [N-1:0] POS_SAT = N'(sat_max(N));
  localparam logic [N-1:0] NEG_SAT = N'(sat_min(N));

  logic [MW-1:0] mag;
  logic [MW-1:0] lim;

  always_comb begin
    mag = {1'b0, prod >> Q};
    if (rnd == RND_HALF_AWAY) begin
      mag = mag + MW'(prod[Q-1]);
    end
    // Negative side reaches one further than positive (2^(N-1) vs 2^(N-1)-1).
    lim = sign ? MW'(sat_min(N)) : MW'(sat_max(N));
    ovf = (mag > lim);
    if (ovf) begin
      res = sign ? NEG_SAT : POS_SAT;
    end else begin
      res = sign ? -mag[N-1:0] : mag[N-1:0];
    end
  end

endmodule

// File: rtl/multu_pipe.sv
// Three-stage signed Q-format multiplier with valid/ready flow control,
// selectable rounding, saturation and a sticky overflow flag.
module multu_pipe
  import multu_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned Q = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] mul1,
  input  logic [N-1:0] mul2,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         ovf,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  logic               stall;

  logic               v1_q, v1_d;
  stage_ctl_t         ctl1_q, ctl1_d;
  logic [N-1:0]       ma1_q, ma1_d;
  logic [N-1:0]       mb1_q, mb1_d;

  logic               v2_q, v2_d;
  stage_ctl_t         ctl2_q, ctl2_d;
  logic [2*N-1:0]     prod2_q, prod2_d;

  logic               out_valid_q, out_valid_d;
  logic [N-1:0]       result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               sticky_q, sticky_d;

  logic [N-1:0]       sr_res;
  logic               sr_ovf;

  multu_sat_round #(.N(N), .Q(Q)) u_sat_round (
    .prod (prod2_q),
    .sign (ctl2_q.sign),
    .rnd  (ctl2_q.rnd),
    .res  (sr_res),
    .ovf  (sr_ovf)
  );

  always_comb begin
    stall       = out_valid_q & ~out_ready;
    v1_d        = v1_q;
    ctl1_d      = ctl1_q;
    ma1_d       = ma1_q;
    mb1_d       = mb1_q;
    v2_d        = v2_q;
    ctl2_d      = ctl2_q;
    prod2_d     = prod2_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    ovf_d       = ovf_q;

    // Single global enable: the whole pipe freezes while the output is held.
    if (!stall) begin
      v1_d        = in_valid;
      ctl1_d.sign = mul1[N-1] ^ mul2[N-1];
      ctl1_d.rnd  = rnd_e'(rnd_mode);
      ma1_d       = mul1[N-1] ? -mul1 : mul1;
      mb1_d       = mul2[N-1] ? -mul2 : mul2;

      v2_d        = v1_q;
      ctl2_d      = ctl1_q;
      prod2_d     = (2*N)'(ma1_q) * (2*N)'(mb1_q);

      out_valid_d = v2_q;
      result_d    = sr_res;
      ovf_d       = sr_ovf;
    end

    sticky_d = sticky_q;
    if (clr_sticky) begin
      sticky_d = 1'b0;
    end
    if (out_valid_q && out_ready && ovf_q) begin
      sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      ctl1_q      <= '0;
      ma1_q       <= '0;
      mb1_q       <= '0;
      v2_q        <= 1'b0;
      ctl2_q      <= '0;
      prod2_q     <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      ctl1_q      <= ctl1_d;
      ma1_q       <= ma1_d;
      mb1_q       <= mb1_d;
      v2_q        <= v2_d;
      ctl2_q      <= ctl2_d;
      prod2_q     <= prod2_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      sticky_q    <= sticky_d;
    end
  end

  assign in_ready   = ~stall;
  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign ovf        = ovf_q;
  assign ovf_sticky = sticky_q;

endmodule
